gemm_tile_scheduler: RTL and testbench
======================================

# gemm_tile_scheduler

Hardware tiling sequencer for the `gemm` accelerator. It accepts a whole-matrix problem (C = A·B; dimensions M, K, N; base addresses; row strides) and walks the n→m→k tile loop nest. For each tile it writes the GEMM configuration registers over the system bus, then polls the full and done flags. It sits between the host register file and the `gemm` system-bus slave port, replacing software-driven tile loops.

## Interface
Parameters:
- `BASE_ADDR`, 32'h9000_0000: GEMM register block base.
- `BLKN`, SUPER_SYS_ROWS: N tile width; must be ≤31.
- `BLKK`, SUPER_SYS_COLS: K tile depth; must be ≤31.
- `BLKM`, 16: M tile height; must be ≤31.
- `DIM_W`, 16: width of the problem-dimension inputs.

Ports:
- `clk`  input  1  clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `cfg_m`, `cfg_k`, `cfg_n`  input  DIM_W  problem dimensions.
- `cfg_a_base`, `cfg_b_base`, `cfg_c_base`  input  32  matrix base addresses, in element units.
- `busy`  output  1  high from the cycle after an accepted start until FINISH.
- `done`  output  1  one-cycle pulse in FINISH.
- `tile_count`  output  16  tiles issued since the last start.
- `bus_en`, `bus_rdwr`  output  1  system-bus enable; rdwr=1 means write.
- `bus_addr`, `bus_wr_data`  output  32  system-bus address and write data.
- `bus_rd_data`  input  32  combinational read data, valid in the same cycle as the address.

## Operation
Register map (offset from BASE_ADDR):
- +0: write tile_A address; read returns 1 while the tile queue is full.
- +4: tile_B address.
- +8: tile_C address.
- +12: A stride.
- +16: B stride.
- +20: control, {first, last}.
- +24: write DIM = msize | ksize<<5 | nsize<<10; read returns 1 when the GEMM is done.

States:
- IDLE: on `start`, latch all cfg inputs and clear n, m, k and `tile_count`.
  - If any dimension is 0, go straight to FINISH with no bus traffic.
  - Otherwise go to CALC.
- CALC, one cycle. Compute:
  - nsize = min(BLKN, N−n); msize = min(BLKM, M−m); ksize = min(BLKK, K−k)
  - first = (k==0); last = (k+BLKK ≥ K)
  - tileA = a_base + k + m·K
  - tileB = b_base + n + k·N + (ksize−1)·N
  - tileC = c_base + n + m·N
- Write states, one write per cycle, in this order: WR_ASTR (data K), WR_BSTR (data N), WR_A, WR_B, WR_C, WR_CTRL, WR_DIM. `tile_count` increments in WR_DIM.
- POLL_FULL: read +0 every cycle. Stay while rd_data==1; otherwise go to ADV.
- ADV: k += BLKK.
  - If k wraps, clear k and set m += BLKM.
  - If m also wraps, go to POLL_DONE.
  - Otherwise go to CALC.
- POLL_DONE: read +24 every cycle until rd_data==1. Then n += BLKN.
  - If n wraps, go to FINISH.
  - Otherwise clear m and go to CALC.
- FINISH: pulse `done` for one cycle, then go to IDLE.

Arithmetic and boundary rules:
- All address arithmetic is 32-bit, modulo 2^32; no overflow flag.
- Size fields are 5 bits, zero-extended.
- A `start` asserted while `busy` is ignored, and the latched configuration is unaffected.

## Timing
- Reset values: `busy`=0, `done`=0, `tile_count`=0, `bus_en`=0, `bus_rdwr`=0, `bus_addr`=0, `bus_wr_data`=0; state is IDLE.
- Reset mid-operation: all outputs return to their reset values asynchronously, with no partial write completing after reset.
- `bus_en`, `bus_rdwr`, `bus_addr` and `bus_wr_data` are registered.
- Writes: `bus_en`=1 and `bus_rdwr`=1 in each write state. The transfer completes at the edge that leaves the state.
- Reads: `bus_en`=1 and `bus_rdwr`=0, with `bus_rd_data` sampled at the edge that leaves the poll cycle.
- Minimum tile issue time: 10 cycles (CALC, 7 writes, 1 poll, ADV).
- start→first write latency: 3 cycles.
- `bus_en`=0 in IDLE, CALC, ADV and FINISH.

## Structure
- Register offsets and the state enum go in the shared `Config` package, next to SUPER_SYS_ROWS and SUPER_SYS_COLS.
- One sub-module, `tile_size_calc`: a combinational clamp that produces size = min(BLK, DIM−idx) and the wrap flag, instantiated three times.

## Test plan
All scenarios use BLKN=BLKK=8, BLKM=16 and a stub GEMM slave.
- M=K=N=16; bases 0, 256, 512; full always 0.
  - Expect 4 tiles and `tile_count`=4.
  - Tile 0 writes A=0, B=368, C=512, ctrl=2'b10, DIM=8464.
  - Tile 1 writes A=8, B=496, ctrl=2'b01.
- M=20, K=12, N=8; bases 0, 240, 336.
  - The tile at m=16, k=8 writes B=328, DIM=8324, ctrl=2'b01.
- Hold full=1 for 5 cycles: expect 5 reads of +0 and no write until it drops.
- Done flag delayed 20 cycles: expect 20 reads of +24, and n=8 tiles issued only after done.
- `cfg_m`=0: expect `done` 2 cycles after `start`, `bus_en` never asserted, `tile_count`=0.
- `rst` low during WR_B: expect all outputs zero immediately. A new `start` then replays from tile 0.

Source files
------------

// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared definitions for the GEMM tile scheduler: array geometry, register map, FSM states.
package gemm_tile_scheduler_pkg;

  localparam int SUPER_SYS_ROWS = 8;
  localparam int SUPER_SYS_COLS = 8;

  localparam logic [31:0] OFF_TILE_A   = 32'd0;
  localparam logic [31:0] OFF_TILE_B   = 32'd4;
  localparam logic [31:0] OFF_TILE_C   = 32'd8;
  localparam logic [31:0] OFF_A_STRIDE = 32'd12;
  localparam logic [31:0] OFF_B_STRIDE = 32'd16;
  localparam logic [31:0] OFF_CTRL     = 32'd20;
  localparam logic [31:0] OFF_DIM      = 32'd24;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CALC,
    ST_WR_ASTR,
    ST_WR_BSTR,
    ST_WR_A,
    ST_WR_B,
    ST_WR_C,
    ST_WR_CTRL,
    ST_WR_DIM,
    ST_POLL_FULL,
    ST_ADV,
    ST_POLL_DONE,
    ST_FINISH
  } state_e;

  // DIM register layout: msize in [4:0], ksize in [9:5], nsize in [14:10].
  function automatic logic [31:0] pack_dim(input logic [4:0] msize,
                                           input logic [4:0] ksize,
                                           input logic [4:0] nsize);
    return {17'd0, nsize, ksize, msize};
  endfunction

endpackage

// File: rtl/gemm_tile_scheduler_size.sv
// Edge-tile clamp: size = min(BLK, dim - idx), wrap when the next step reaches or passes dim.
module tile_size_calc #(
  parameter int DIM_W = 16,
  parameter int BLK   = 8
) (
  input  logic [DIM_W-1:0] dim,
  input  logic [DIM_W-1:0] idx,
  output logic [4:0]       size,
  output logic             wrap
);

  localparam logic [DIM_W:0] BLK_X = (DIM_W + 1)'(BLK);

  logic [DIM_W:0] remain;
  logic [DIM_W:0] idx_next;

  // One extra bit so idx + BLK cannot alias back below dim.
  always_comb begin
    remain   = {1'b0, dim} - {1'b0, idx};
    idx_next = {1'b0, idx} + BLK_X;
    wrap     = (idx_next >= {1'b0, dim});
    size     = (remain > BLK_X) ? 5'(BLK) : remain[4:0];
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks the n->m->k tile nest of C = A*B, programming each tile into the GEMM register block
// over the system bus and polling its queue-full / done flags; bus outputs are registered.
module gemm_tile_scheduler
  import gemm_tile_scheduler_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          BLKN      = SUPER_SYS_ROWS,
  parameter int          BLKK      = SUPER_SYS_COLS,
  parameter int          BLKM      = 16,
  parameter int          DIM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic [31:0]      cfg_a_base,
  input  logic [31:0]      cfg_b_base,
  input  logic [31:0]      cfg_c_base,
  output logic             busy,
  output logic             done,
  output logic [15:0]      tile_count,
  output logic             bus_en,
  output logic             bus_rdwr,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wr_data,
  input  logic [31:0]      bus_rd_data
);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] m_dim_q, m_dim_d, k_dim_q, k_dim_d, n_dim_q, n_dim_d;
  logic [31:0]      a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
  logic [31:0]      tile_a_q, tile_a_d, tile_b_q, tile_b_d, tile_c_q, tile_c_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [31:0]      dim_q, dim_d;
  logic [15:0]      tile_count_q, tile_count_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             bus_en_q, bus_en_d, bus_rdwr_q, bus_rdwr_d;
  logic [31:0]      bus_addr_q, bus_addr_d, bus_wr_data_q, bus_wr_data_d;

  logic [4:0] nsize, msize, ksize;
  logic       n_wrap, m_wrap, k_wrap;

  tile_size_calc #(.DIM_W(DIM_W), .BLK(BLKN)) u_n_size (
    .dim(n_dim_q), .idx(n_q), .size(nsize), .wrap(n_wrap)
  );
  tile_size_calc #(.DIM_W(DIM_W), .BLK(BLKM)) u_m_size (
    .dim(m_dim_q), .idx(m_q), .size(msize), .wrap(m_wrap)
  );
  tile_size_calc #(.DIM_W(DIM_W), .BLK(BLKK)) u_k_size (
    .dim(k_dim_q), .idx(k_q), .size(ksize), .wrap(k_wrap)
  );

  always_comb begin
    state_d      = state_q;
    m_dim_d      = m_dim_q;
    k_dim_d      = k_dim_q;
    n_dim_d      = n_dim_q;
    a_base_d     = a_base_q;
    b_base_d     = b_base_q;
    c_base_d     = c_base_q;
    m_d          = m_q;
    k_d          = k_q;
    n_d          = n_q;
    tile_a_d     = tile_a_q;
    tile_b_d     = tile_b_q;
    tile_c_d     = tile_c_q;
    ctrl_d       = ctrl_q;
    dim_d        = dim_q;
    tile_count_d = tile_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_dim_d      = cfg_m;
          k_dim_d      = cfg_k;
          n_dim_d      = cfg_n;
          a_base_d     = cfg_a_base;
          b_base_d     = cfg_b_base;
          c_base_d     = cfg_c_base;
          m_d          = '0;
          k_d          = '0;
          n_d          = '0;
          tile_count_d = '0;
          if ((cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0)) state_d = ST_FINISH;
          else                                                 state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        tile_a_d = a_base_q + 32'(k_q) + 32'(m_q) * 32'(k_dim_q);
        // B is addressed at the last K row of the tile.
        tile_b_d = b_base_q + 32'(n_q) + (32'(k_q) + 32'(ksize) - 32'd1) * 32'(n_dim_q);
        tile_c_d = c_base_q + 32'(n_q) + 32'(m_q) * 32'(n_dim_q);
        ctrl_d   = {(k_q == '0), k_wrap};
        dim_d    = pack_dim(msize, ksize, nsize);
        state_d  = ST_WR_ASTR;
      end
      ST_WR_ASTR: state_d = ST_WR_BSTR;
      ST_WR_BSTR: state_d = ST_WR_A;
      ST_WR_A:    state_d = ST_WR_B;
      ST_WR_B:    state_d = ST_WR_C;
      ST_WR_C:    state_d = ST_WR_CTRL;
      ST_WR_CTRL: state_d = ST_WR_DIM;
      ST_WR_DIM: begin
        tile_count_d = tile_count_q + 16'd1;
        state_d      = ST_POLL_FULL;
      end
      ST_POLL_FULL: begin
        if (bus_rd_data != 32'd1) state_d = ST_ADV;
      end
      ST_ADV: begin
        if (k_wrap) begin
          k_d = '0;
          if (m_wrap) begin
            state_d = ST_POLL_DONE;
          end else begin
            m_d     = m_q + DIM_W'(BLKM);
            state_d = ST_CALC;
          end
        end else begin
          k_d     = k_q + DIM_W'(BLKK);
          state_d = ST_CALC;
        end
      end
      ST_POLL_DONE: begin
        if (bus_rd_data == 32'd1) begin
          if (n_wrap) begin
            state_d = ST_FINISH;
          end else begin
            n_d     = n_q + DIM_W'(BLKN);
            m_d     = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_FINISH);
    bus_en_d      = 1'b1;
    bus_rdwr_d    = 1'b1;
    bus_addr_d    = '0;
    bus_wr_data_d = '0;
    case (state_d)
      ST_WR_ASTR: begin bus_addr_d = BASE_ADDR + OFF_A_STRIDE; bus_wr_data_d = 32'(k_dim_q); end
      ST_WR_BSTR: begin bus_addr_d = BASE_ADDR + OFF_B_STRIDE; bus_wr_data_d = 32'(n_dim_q); end
      ST_WR_A:    begin bus_addr_d = BASE_ADDR + OFF_TILE_A;   bus_wr_data_d = tile_a_q;       end
      ST_WR_B:    begin bus_addr_d = BASE_ADDR + OFF_TILE_B;   bus_wr_data_d = tile_b_q;       end
      ST_WR_C:    begin bus_addr_d = BASE_ADDR + OFF_TILE_C;   bus_wr_data_d = tile_c_q;       end
      ST_WR_CTRL: begin bus_addr_d = BASE_ADDR + OFF_CTRL;     bus_wr_data_d = 32'(ctrl_q);    end
      ST_WR_DIM:  begin bus_addr_d = BASE_ADDR + OFF_DIM;      bus_wr_data_d = dim_q;          end
      ST_POLL_FULL: begin bus_rdwr_d = 1'b0; bus_addr_d = BASE_ADDR + OFF_TILE_A; end
      ST_POLL_DONE: begin bus_rdwr_d = 1'b0; bus_addr_d = BASE_ADDR + OFF_DIM;    end
      default: begin
        bus_en_d   = 1'b0;
        bus_rdwr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      m_dim_q       <= '0;
      k_dim_q       <= '0;
      n_dim_q       <= '0;
      a_base_q      <= '0;
      b_base_q      <= '0;
      c_base_q      <= '0;
      m_q           <= '0;
      k_q           <= '0;
      n_q           <= '0;
      tile_a_q      <= '0;
      tile_b_q      <= '0;
      tile_c_q      <= '0;
      ctrl_q        <= '0;
      dim_q         <= '0;
      tile_count_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      bus_en_q      <= 1'b0;
      bus_rdwr_q    <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      m_dim_q       <= m_dim_d;
      k_dim_q       <= k_dim_d;
      n_dim_q       <= n_dim_d;
      a_base_q      <= a_base_d;
      b_base_q      <= b_base_d;
      c_base_q      <= c_base_d;
      m_q           <= m_d;
      k_q           <= k_d;
      n_q           <= n_d;
      tile_a_q      <= tile_a_d;
      tile_b_q      <= tile_b_d;
      tile_c_q      <= tile_c_d;
      ctrl_q        <= ctrl_d;
      dim_q         <= dim_d;
      tile_count_q  <= tile_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      bus_en_q      <= bus_en_d;
      bus_rdwr_q    <= bus_rdwr_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign tile_count  = tile_count_q;
  assign bus_en      = bus_en_q;
  assign bus_rdwr    = bus_rdwr_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler with a stub GEMM slave that logs every bus access.
module tb_gemm_tile_scheduler;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
  logic [31:0] cfg_a_base = '0, cfg_b_base = '0, cfg_c_base = '0;
  logic        busy, done, bus_en, bus_rdwr;
  logic [15:0] tile_count;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  gemm_tile_scheduler #(.BASE_ADDR(BASE), .BLKN(8), .BLKK(8), .BLKM(16), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
    .busy(busy), .done(done), .tile_count(tile_count),
    .bus_en(bus_en), .bus_rdwr(bus_rdwr), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  // Stub slave: full reads 1 for the first full_hold reads of +0, done reads 0 for the
  // first done_hold reads of +24; counters restart on stub_clr.
  int   full_hold = 0, done_hold = 0;
  int   full_rd_cnt = 0, done_rd_cnt = 0;
  logic stub_clr = 1'b0;

  wire rd0  = bus_en && !bus_rdwr && (bus_addr == BASE);
  wire rd24 = bus_en && !bus_rdwr && (bus_addr == BASE + 32'd24);

  assign bus_rd_data = rd0  ? 32'(full_rd_cnt < full_hold) :
                       rd24 ? 32'(done_rd_cnt >= done_hold) : 32'd0;

  always @(posedge clk) begin
    if (stub_clr) begin
      full_rd_cnt <= 0;
      done_rd_cnt <= 0;
    end else begin
      if (rd0)  full_rd_cnt <= full_rd_cnt + 1;
      if (rd24) done_rd_cnt <= done_rd_cnt + 1;
    end
  end

  typedef struct {
    bit          wr;
    int          off;
    logic [31:0] dat;
  } ev_t;
  ev_t ev_q[$];

  always @(negedge clk) begin
    ev_t e;
    if (bus_en === 1'b1) begin
      e.wr  = bus_rdwr;
      e.off = int'(bus_addr - BASE);
      e.dat = bus_rdwr ? bus_wr_data : bus_rd_data;
      ev_q.push_back(e);
    end
  end

  // Expected bus trace, built by hand per scenario.
  bit          exp_wr[$];
  int          exp_off[$];
  logic [31:0] exp_dat[$];

  task automatic ex_clear();
    exp_wr.delete(); exp_off.delete(); exp_dat.delete();
  endtask

  task automatic ex(input bit wr, input int off, input logic [31:0] d);
    exp_wr.push_back(wr); exp_off.push_back(off); exp_dat.push_back(d);
  endtask

  task automatic ex_tile(input int kk, input int nn, input int a, input int b, input int c,
                         input int ctrl, input int dim);
    ex(1, 12, kk); ex(1, 16, nn); ex(1, 0, a); ex(1, 4, b); ex(1, 8, c);
    ex(1, 20, ctrl); ex(1, 24, dim);
  endtask

  // M=K=N=16, bases 0/256/512: DIM = 16 | 8<<5 | 8<<10 = 8464 for every tile.
  task automatic ex_square(input int full_extra, input int done_extra);
    ex_clear();
    ex_tile(16, 16, 0, 368, 512, 2, 8464);
    for (int i = 0; i < full_extra; i++) ex(0, 0, 1);
    ex(0, 0, 0);
    ex_tile(16, 16, 8, 496, 512, 1, 8464);
    ex(0, 0, 0);
    for (int i = 0; i < done_extra; i++) ex(0, 24, 0);
    ex(0, 24, 1);
    ex_tile(16, 16, 0, 376, 520, 2, 8464);
    ex(0, 0, 0);
    ex_tile(16, 16, 8, 504, 520, 1, 8464);
    ex(0, 0, 0);
    ex(0, 24, 1);
  endtask

  task automatic do_start(input int m, input int k, input int n,
                          input int a, input int b, input int c);
    @(negedge clk);
    cfg_m = 16'(m); cfg_k = 16'(k); cfg_n = 16'(n);
    cfg_a_base = 32'(a); cfg_b_base = 32'(b); cfg_c_base = 32'(c);
    ev_q.delete();
    stub_clr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stub_clr = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({busy, done, tile_count, bus_en, bus_rdwr, bus_addr, bus_wr_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b tc=%0d en=%b rdwr=%b addr=%h wd=%h, want all 0",
               busy, done, tile_count, bus_en, bus_rdwr, bus_addr, bus_wr_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_square();
    bit ok;
    full_hold = 0; done_hold = 0;
    ex_square(0, 0);
    do_start(16, 16, 16, 0, 256, 512);
    // Counting the start cycle as cycle 1: busy and CALC in cycle 2, first write in cycle 3.
    n_cmp++;
    if (busy !== 1'b1 || bus_en !== 1'b0) begin
      n_err++; $display("FAIL sq_cycle2: busy=%b bus_en=%b, want 1 0", busy, bus_en);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_en !== 1'b1 || bus_rdwr !== 1'b1 || bus_addr !== BASE + 32'd12 || bus_wr_data !== 32'd16) begin
      n_err++;
      $display("FAIL sq_first_write: en=%b rdwr=%b addr=%h data=%0d, want 1 1 %h 16",
               bus_en, bus_rdwr, bus_addr, bus_wr_data, BASE + 32'd12);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL sq_done_timeout: done=%b, want 1", done); end
    n_cmp++;
    if (tile_count !== 16'd4 || busy !== 1'b1) begin
      n_err++; $display("FAIL sq_finish: tile_count=%0d busy=%b, want 4 1", tile_count, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL sq_done_pulse: done=%b busy=%b after FINISH, want 0 0", done, busy);
    end
    n_cmp++;
    if (ev_q.size() != exp_wr.size()) begin
      n_err++; $display("FAIL sq_trace_len: got %0d accesses, want %0d", ev_q.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < ev_q.size(); i++) begin
      n_cmp++;
      if (ev_q[i].wr !== exp_wr[i] || ev_q[i].off != exp_off[i] || ev_q[i].dat !== exp_dat[i]) begin
        n_err++;
        $display("FAIL sq_ev%0d: got wr=%0d off=%0d dat=%0d, want wr=%0d off=%0d dat=%0d",
                 i, ev_q[i].wr, ev_q[i].off, ev_q[i].dat, exp_wr[i], exp_off[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_rect();
    bit ok;
    full_hold = 0; done_hold = 0;
    ex_clear();
    ex_tile(12, 8,   0, 296, 336, 2, 8464); ex(0, 0, 0);
    ex_tile(12, 8,   8, 328, 336, 1, 8336); ex(0, 0, 0);
    ex_tile(12, 8, 192, 296, 464, 2, 8452); ex(0, 0, 0);
    ex_tile(12, 8, 200, 328, 464, 1, 8324); ex(0, 0, 0);
    ex(0, 24, 1);
    do_start(20, 12, 8, 0, 240, 336);
    wait_done(ok);
    n_cmp++;
    if (!ok || tile_count !== 16'd4) begin
      n_err++; $display("FAIL rect_finish: done_seen=%0d tile_count=%0d, want 1 4", ok, tile_count);
    end
    n_cmp++;
    if (ev_q.size() != exp_wr.size()) begin
      n_err++; $display("FAIL rect_trace_len: got %0d accesses, want %0d", ev_q.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < ev_q.size(); i++) begin
      n_cmp++;
      if (ev_q[i].wr !== exp_wr[i] || ev_q[i].off != exp_off[i] || ev_q[i].dat !== exp_dat[i]) begin
        n_err++;
        $display("FAIL rect_ev%0d: got wr=%0d off=%0d dat=%0d, want wr=%0d off=%0d dat=%0d",
                 i, ev_q[i].wr, ev_q[i].off, ev_q[i].dat, exp_wr[i], exp_off[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_full_hold();
    bit ok;
    full_hold = 5; done_hold = 0;
    ex_square(5, 0);
    do_start(16, 16, 16, 0, 256, 512);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL full_done_timeout: done=%b, want 1", done); end
    n_cmp++;
    if (ev_q.size() != exp_wr.size()) begin
      n_err++; $display("FAIL full_trace_len: got %0d accesses, want %0d", ev_q.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < ev_q.size(); i++) begin
      n_cmp++;
      if (ev_q[i].wr !== exp_wr[i] || ev_q[i].off != exp_off[i] || ev_q[i].dat !== exp_dat[i]) begin
        n_err++;
        $display("FAIL full_ev%0d: got wr=%0d off=%0d dat=%0d, want wr=%0d off=%0d dat=%0d",
                 i, ev_q[i].wr, ev_q[i].off, ev_q[i].dat, exp_wr[i], exp_off[i], exp_dat[i]);
      end
    end
    full_hold = 0;
  endtask

  task automatic test_done_delay();
    bit ok;
    full_hold = 0; done_hold = 20;
    ex_square(0, 20);
    do_start(16, 16, 16, 0, 256, 512);
    wait_done(ok);
    n_cmp++;
    if (!ok || tile_count !== 16'd4) begin
      n_err++; $display("FAIL dly_finish: done_seen=%0d tile_count=%0d, want 1 4", ok, tile_count);
    end
    n_cmp++;
    if (ev_q.size() != exp_wr.size()) begin
      n_err++; $display("FAIL dly_trace_len: got %0d accesses, want %0d", ev_q.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < ev_q.size(); i++) begin
      n_cmp++;
      if (ev_q[i].wr !== exp_wr[i] || ev_q[i].off != exp_off[i] || ev_q[i].dat !== exp_dat[i]) begin
        n_err++;
        $display("FAIL dly_ev%0d: got wr=%0d off=%0d dat=%0d, want wr=%0d off=%0d dat=%0d",
                 i, ev_q[i].wr, ev_q[i].off, ev_q[i].dat, exp_wr[i], exp_off[i], exp_dat[i]);
      end
    end
    done_hold = 0;
  endtask

  task automatic test_zero_dim();
    int dims[3][3];
    dims = '{'{0, 16, 16}, '{16, 0, 16}, '{16, 16, 0}};
    for (int p = 0; p < 3; p++) begin
      do_start(dims[p][0], dims[p][1], dims[p][2], 0, 256, 512);
      // Start cycle is cycle 1; done pulses in cycle 2.
      n_cmp++;
      if (done !== 1'b1 || tile_count !== 16'd0) begin
        n_err++; $display("FAIL zero%0d_done: done=%b tile_count=%0d, want 1 0", p, done, tile_count);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL zero%0d_idle: done=%b busy=%b, want 0 0", p, done, busy);
      end
      n_cmp++;
      if (ev_q.size() != 0) begin
        n_err++; $display("FAIL zero%0d_bus: got %0d bus accesses, want 0", p, ev_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok, hit;
    full_hold = 0; done_hold = 0;
    do_start(16, 16, 16, 0, 256, 512);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (bus_en === 1'b1 && bus_rdwr === 1'b1 && bus_addr === BASE + 32'd4) hit = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL rst_find_wrb: WR_B not seen, want seen"); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, tile_count, bus_en, bus_rdwr, bus_addr, bus_wr_data} !== '0) begin
      n_err++;
      $display("FAIL rst_async: busy=%b done=%b tc=%0d en=%b rdwr=%b addr=%h wd=%h, want all 0",
               busy, done, tile_count, bus_en, bus_rdwr, bus_addr, bus_wr_data);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_en !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_held: bus_en=%b busy=%b, want 0 0", bus_en, busy);
    end
    rst = 1'b1;
    ex_square(0, 0);
    do_start(16, 16, 16, 0, 256, 512);
    wait_done(ok);
    n_cmp++;
    if (!ok || tile_count !== 16'd4) begin
      n_err++; $display("FAIL rst_replay: done_seen=%0d tile_count=%0d, want 1 4", ok, tile_count);
    end
    n_cmp++;
    if (ev_q.size() != exp_wr.size()) begin
      n_err++; $display("FAIL rst_trace_len: got %0d accesses, want %0d", ev_q.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < ev_q.size(); i++) begin
      n_cmp++;
      if (ev_q[i].wr !== exp_wr[i] || ev_q[i].off != exp_off[i] || ev_q[i].dat !== exp_dat[i]) begin
        n_err++;
        $display("FAIL rst_ev%0d: got wr=%0d off=%0d dat=%0d, want wr=%0d off=%0d dat=%0d",
                 i, ev_q[i].wr, ev_q[i].off, ev_q[i].dat, exp_wr[i], exp_off[i], exp_dat[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_zero_dim();
    test_rect();
    test_full_hold();
    test_done_delay();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
